// File: rtl/croc_pkg.sv
// Minimal OBI subordinate channel types used as the default request/response
// types of the user-domain peripherals.
package croc_pkg;

   localparam int unsigned SbrObiIdWidth = 4;

   typedef struct packed {
      logic [31:0]              addr;
      logic                     we;
      logic [3:0]               be;
      logic [31:0]              wdata;
      logic [SbrObiIdWidth-1:0] aid;
   } sbr_obi_a_chan_t;

   typedef struct packed {
      sbr_obi_a_chan_t a;
      logic            req;
   } sbr_obi_req_t;

   typedef struct packed {
      logic [31:0]              rdata;
      logic [SbrObiIdWidth-1:0] rid;
      logic                     err;
   } sbr_obi_r_chan_t;

   typedef struct packed {
      logic            gnt;
      logic            rvalid;
      sbr_obi_r_chan_t r;
   } sbr_obi_rsp_t;

endpackage

// File: rtl/user_pkg.sv
// User-domain address map plus the edge-detect register map, CTRL bit
// positions and small decode helpers.
package user_pkg;

   // Base of the edge-detect window inside the user domain.
   localparam logic [31:0] UserEdgeDetectAddrOffset = 32'h2000_1000;

   // Word offsets (addr[11:2]) of the edge-detect registers.
   localparam logic [9:0] EdgeCtrlWordOff   = 10'h000;
   localparam logic [9:0] EdgeStatusWordOff = 10'h001;
   localparam logic [9:0] EdgeCountWordOff  = 10'h002;
   localparam logic [9:0] EdgeMaskWordOff   = 10'h003;
   localparam logic [9:0] EdgeLevelWordOff  = 10'h004;

   // CTRL bit positions.
   localparam int unsigned EdgeCtrlEnBit   = 0;
   localparam int unsigned EdgeCtrlRiseBit = 1;
   localparam int unsigned EdgeCtrlFallBit = 2;
   localparam int unsigned EdgeCtrlWidth   = 3;

   typedef enum logic [2:0] {
      EdgeRegCtrl,
      EdgeRegStatus,
      EdgeRegCount,
      EdgeRegMask,
      EdgeRegLevel,
      EdgeRegNone
   } edge_reg_e;

   // Map a word offset onto a register; anything unmapped is EdgeRegNone.
   function automatic edge_reg_e edge_reg_decode(input logic [9:0] word_off);
      edge_reg_e sel;
      case (word_off)
         EdgeCtrlWordOff:   sel = EdgeRegCtrl;
         EdgeStatusWordOff: sel = EdgeRegStatus;
         EdgeCountWordOff:  sel = EdgeRegCount;
         EdgeMaskWordOff:   sel = EdgeRegMask;
         EdgeLevelWordOff:  sel = EdgeRegLevel;
         default:           sel = EdgeRegNone;
      endcase
      return sel;
   endfunction

   // Expand the four byte enables into a 32-bit write mask.
   function automatic logic [31:0] be_to_bitmask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/sync.sv
// Multi-stage flop synchronizer for one asynchronous bit, synchronous reset.
module sync #(
   parameter int unsigned STAGES     = 2,
   parameter bit          ResetValue = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic serial_i,
   output logic serial_o
);

   logic [STAGES-1:0] reg_q;
   logic [STAGES-1:0] reg_d;

   // Shift the raw input one stage deeper each cycle.
   always_comb begin
      reg_d = {reg_q[STAGES-2:0], serial_i};
   end

   // Synchronizer chain.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         reg_q <= {STAGES{ResetValue}};
      end else begin
         reg_q <= reg_d;
      end
   end

   assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/user_edge_detect.sv
// Edge-detect peripheral: synchronizes NumInputs async lines, flags qualified
// rising/falling edges in sticky STATUS bits, counts them in a saturating
// COUNT and raises a level interrupt for unmasked pending bits.
// OBI handshake: gnt is req (no backpressure); every granted request gets
// exactly one rvalid in the following cycle carrying the captured aid as rid.
// Reads return state from before any same-cycle write; writes return rdata 0.
module user_edge_detect import user_pkg::*; #(
   parameter int unsigned NumInputs = 8,
   parameter type obi_req_t = croc_pkg::sbr_obi_req_t,
   parameter type obi_rsp_t = croc_pkg::sbr_obi_rsp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  obi_req_t             obi_req_i,
   output obi_rsp_t             obi_rsp_o,
   input  logic [NumInputs-1:0] edge_i,
   output logic                 irq_o
);

   localparam int unsigned IdW = croc_pkg::SbrObiIdWidth;

   logic [EdgeCtrlWidth-1:0] ctrl_q,   ctrl_d;
   logic [NumInputs-1:0]     status_q, status_d;
   logic [NumInputs-1:0]     mask_q,   mask_d;
   logic [NumInputs-1:0]     prev_q,   prev_d;
   logic [15:0]              count_q,  count_d;
   logic                     irq_q,    irq_d;
   logic                     rvalid_q, rvalid_d;
   logic [IdW-1:0]           rid_q,    rid_d;
   logic [31:0]              rdata_q,  rdata_d;
   logic                     err_q,    err_d;

   logic [NumInputs-1:0] sync_val;
   logic                 req_valid;
   logic                 wr_en;
   edge_reg_e            reg_sel;
   logic [31:0]          byte_mask;
   logic [31:0]          rd_data;
   logic                 rd_err;
   logic [NumInputs-1:0] rise;
   logic [NumInputs-1:0] fall;
   logic [NumInputs-1:0] qual_evt;
   logic [NumInputs-1:0] status_clr;
   logic [5:0]           evt_cnt;
   logic [16:0]          count_sum;
   logic                 unused_req;

   assign unused_req = ^obi_req_i;

   for (genvar i = 0; i < NumInputs; i++) begin : gen_sync
      sync #(
         .STAGES     (2),
         .ResetValue (1'b0)
      ) i_sync (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .serial_i (edge_i[i]),
         .serial_o (sync_val[i])
      );
   end

   // Decode the bus request and select read data from current register state.
   always_comb begin
      req_valid = obi_req_i.req;
      wr_en     = obi_req_i.req & obi_req_i.a.we;
      reg_sel   = edge_reg_decode(obi_req_i.a.addr[11:2]);
      byte_mask = be_to_bitmask(obi_req_i.a.be);
      rd_err    = (reg_sel == EdgeRegNone);
      rd_data   = '0;
      case (reg_sel)
         EdgeRegCtrl:   rd_data = 32'(ctrl_q);
         EdgeRegStatus: rd_data = 32'(status_q);
         EdgeRegCount:  rd_data = 32'(count_q);
         EdgeRegMask:   rd_data = 32'(mask_q);
         EdgeRegLevel:  rd_data = 32'(sync_val);
         default:       rd_data = '0;
      endcase
   end

   // Edge qualification, register updates and the registered response.
   always_comb begin
      rise     = sync_val & ~prev_q;
      fall     = ~sync_val & prev_q;
      qual_evt = {NumInputs{ctrl_q[EdgeCtrlEnBit]}} &
                 (({NumInputs{ctrl_q[EdgeCtrlRiseBit]}} & rise) |
                  ({NumInputs{ctrl_q[EdgeCtrlFallBit]}} & fall));
      evt_cnt = '0;
      for (int i = 0; i < NumInputs; i++) begin
         evt_cnt = evt_cnt + 6'(qual_evt[i]);
      end

      ctrl_d = ctrl_q;
      if (wr_en && reg_sel == EdgeRegCtrl && obi_req_i.a.be[0]) begin
         ctrl_d = obi_req_i.a.wdata[EdgeCtrlWidth-1:0];
      end

      mask_d = mask_q;
      if (wr_en && reg_sel == EdgeRegMask) begin
         mask_d = (mask_q & ~byte_mask[NumInputs-1:0]) |
                  (obi_req_i.a.wdata[NumInputs-1:0] & byte_mask[NumInputs-1:0]);
      end

      // A same-cycle event re-sets a bit the write is clearing.
      status_clr = '0;
      if (wr_en && reg_sel == EdgeRegStatus) begin
         status_clr = obi_req_i.a.wdata[NumInputs-1:0] & byte_mask[NumInputs-1:0];
      end
      status_d = (status_q & ~status_clr) | qual_evt;

      count_sum = 17'(count_q) + 17'(evt_cnt);
      if (wr_en && reg_sel == EdgeRegCount) begin
         count_d = 16'(evt_cnt);
      end else if (count_sum[16]) begin
         count_d = 16'hFFFF;
      end else begin
         count_d = count_sum[15:0];
      end

      // History always tracks the synchronized input, even while disabled.
      prev_d = sync_val;
      irq_d  = |(status_d & mask_d);

      rvalid_d = req_valid;
      rid_d    = rid_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      if (req_valid) begin
         rid_d   = obi_req_i.a.aid;
         rdata_d = obi_req_i.a.we ? 32'h0 : rd_data;
         err_d   = rd_err;
      end
   end

   // All state, synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ctrl_q   <= '0;
         status_q <= '0;
         mask_q   <= '0;
         prev_q   <= '0;
         count_q  <= '0;
         irq_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rid_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         status_q <= status_d;
         mask_q   <= mask_d;
         prev_q   <= prev_d;
         count_q  <= count_d;
         irq_q    <= irq_d;
         rvalid_q <= rvalid_d;
         rid_q    <= rid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Response channel: grant is immediate, everything else comes from flops.
   always_comb begin
      obi_rsp_o         = '0;
      obi_rsp_o.gnt     = req_valid;
      obi_rsp_o.rvalid  = rvalid_q;
      obi_rsp_o.r.rdata = rdata_q;
      obi_rsp_o.r.rid   = rid_q;
      obi_rsp_o.r.err   = err_q;
   end

   assign irq_o = irq_q;

endmodule

// File: tb/tb_user_edge_detect.sv
// Directed bench for user_edge_detect: driver tasks issue OBI accesses and push
// the expected response; a monitor pops and compares on every rvalid.
module tb_user_edge_detect;
   import croc_pkg::*;

   localparam int unsigned N = 8;
   localparam int W = 1 + SbrObiIdWidth + 32;

   logic         clk = 1'b0;
   logic         rst_n;
   sbr_obi_req_t req_s;
   sbr_obi_rsp_t rsp_s;
   logic [N-1:0] edge_r;
   logic         irq;

   logic [W-1:0]             exp_q[$];
   logic [SbrObiIdWidth-1:0] tag;
   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   user_edge_detect #(
      .NumInputs (N),
      .obi_req_t (sbr_obi_req_t),
      .obi_rsp_t (sbr_obi_rsp_t)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .obi_req_i (req_s),
      .obi_rsp_o (rsp_s),
      .edge_i    (edge_r),
      .irq_o     (irq)
   );

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic bad_off(input logic [31:0] addr);
      return addr[11:2] > 10'd4;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata);
      logic err;
      @(negedge clk);
      err           = bad_off(addr);
      req_s.req     = 1'b1;
      req_s.a.we    = we;
      req_s.a.addr  = addr;
      req_s.a.wdata = wdata;
      req_s.a.be    = be;
      req_s.a.aid   = tag;
      exp_q.push_back({err, tag, (we ? 32'h0 : exp_rdata)});
      tag = tag + 1'b1;
      #1;
      check("gnt", 32'(rsp_s.gnt), 32'h1);
   endtask

   task automatic idle();
      @(negedge clk);
      req_s.req  = 1'b0;
      req_s.a.we = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      issue(1'b1, addr, data, be, 32'h0);
      idle();
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
      issue(1'b0, addr, 32'h0, 4'hF, exp);
      idle();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      if (rsp_s.rvalid === 1'b1) begin
         checks++;
         a = {rsp_s.r.err, rsp_s.r.rid, rsp_s.r.rdata};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid: got rvalid=1 {err,rid,rdata}=0x%0h expected no response", a);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL rsp: got {err,rid,rdata}=0x%0h expected 0x%0h", a, e);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      req_s  = '0;
      edge_r = '0;
      tag    = '0;
      rst_n  = 1'b0;
      wait_cycles(2);
      check("rvalid_in_reset", 32'(rsp_s.rvalid), 32'h0);
      check("irq_in_reset", 32'(irq), 32'h0);
      rst_n = 1'b1;
      wait_cycles(1);

      // reset values
      rd(32'h00, 32'h0);
      rd(32'h04, 32'h0);
      rd(32'h08, 32'h0);
      rd(32'h0C, 32'h0);
      rd(32'h10, 32'h0);

      // Case 1: rising edge on bit 0, two-edge latency into STATUS
      wr(32'h00, 32'h3, 4'hF);
      wr(32'h0C, 32'h1, 4'hF);
      @(negedge clk); edge_r[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("irq_before_latency", 32'(irq), 32'h0);
      @(negedge clk);
      check("irq_after_latency", 32'(irq), 32'h1);
      rd(32'h04, 32'h01);
      rd(32'h08, 32'h1);
      rd(32'h10, 32'h01);

      // Case 2: RW1C clear, then clear colliding with a new event
      wr(32'h04, 32'h1, 4'hF);
      check("irq_after_clear", 32'(irq), 32'h0);
      edge_r[0] = 1'b0;
      wait_cycles(4);
      rd(32'h08, 32'h1);
      rd(32'h04, 32'h0);
      @(negedge clk); edge_r[0] = 1'b1;
      @(negedge clk);
      wr(32'h04, 32'h1, 4'hF);
      check("irq_event_beats_clear", 32'(irq), 32'h1);
      rd(32'h04, 32'h01);
      rd(32'h08, 32'h2);

      // byte enables and CTRL unused bits
      wr(32'h0C, 32'hFFFF_FFFF, 4'h0);
      rd(32'h0C, 32'h01);
      wr(32'h00, 32'h0, 4'hE);
      rd(32'h00, 32'h3);
      wr(32'h00, 32'hFFFF_FFFF, 4'hF);
      rd(32'h00, 32'h7);
      wr(32'h0C, 32'h0000_FF00, 4'h2);
      rd(32'h0C, 32'h01);

      // Case 3: all inputs toggle 0x00->0xFF->0x00 with both edges enabled
      edge_r = 8'h00;
      wait_cycles(4);
      wr(32'h08, 32'h0, 4'hF);
      wr(32'h04, 32'hFF, 4'hF);
      edge_r = 8'hFF;
      wait_cycles(4);
      edge_r = 8'h00;
      wait_cycles(4);
      rd(32'h08, 32'd16);
      rd(32'h04, 32'hFF);
      rd(32'h10, 32'h00);
      check("irq_case3", 32'(irq), 32'h1);

      // COUNT write in the same cycle as 8 events -> 8
      @(negedge clk); edge_r = 8'hFF;
      @(negedge clk);
      wr(32'h08, 32'h0, 4'hF);
      rd(32'h08, 32'd8);
      edge_r = 8'h00;
      wait_cycles(4);
      rd(32'h08, 32'd16);

      // EN=0: edges tracked by prev but not recorded
      wr(32'h00, 32'h6, 4'hF);
      wr(32'h08, 32'h0, 4'hF);
      wr(32'h04, 32'hFF, 4'hF);
      check("irq_cleared_all", 32'(irq), 32'h0);
      edge_r = 8'hFF;
      wait_cycles(4);
      wr(32'h00, 32'h7, 4'hF);
      wait_cycles(4);
      rd(32'h08, 32'h0);
      rd(32'h04, 32'h0);
      edge_r = 8'hF0;
      wait_cycles(4);
      rd(32'h04, 32'h0F);
      rd(32'h08, 32'd4);

      // Case 4: saturation
      edge_r = 8'h00;
      wait_cycles(4);
      wr(32'h08, 32'h0, 4'hF);
      for (int i = 0; i < 8191; i++) begin
         @(negedge clk);
         edge_r = ~edge_r;
      end
      wait_cycles(4);
      rd(32'h08, 32'hFFF8);
      @(negedge clk); edge_r = ~edge_r;
      wait_cycles(4);
      rd(32'h08, 32'hFFFF);
      @(negedge clk); edge_r = ~edge_r;
      wait_cycles(4);
      rd(32'h08, 32'hFFFF);
      wr(32'h08, 32'h1234, 4'hF);
      rd(32'h08, 32'h0);

      // Case 5: unmapped offset and back-to-back accesses
      rd(32'h14, 32'h0);
      wr(32'h14, 32'hFFFF_FFFF, 4'hF);
      rd(32'h00, 32'h7);
      issue(1'b0, 32'h00, 32'h0, 4'hF, 32'h7);
      issue(1'b0, 32'h0C, 32'h0, 4'hF, 32'h01);
      issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hFF);
      issue(1'b0, 32'h14, 32'h0, 4'hF, 32'h0);
      issue(1'b0, 32'h04, 32'h0, 4'hF, 32'hFF);
      idle();
      @(negedge clk);
      check("queue_drained_b2b", 32'(exp_q.size()), 32'h0);

      // Case 6: reset while a read is outstanding
      edge_r = 8'h00;
      wait_cycles(4);
      @(negedge clk);
      req_s.req    = 1'b1;
      req_s.a.we   = 1'b0;
      req_s.a.addr = 32'h04;
      req_s.a.aid  = tag;
      tag          = tag + 1'b1;
      rst_n        = 1'b0;
      @(negedge clk);
      req_s.req = 1'b0;
      rst_n     = 1'b1;
      check("rvalid_dropped", 32'(rsp_s.rvalid), 32'h0);
      check("irq_after_reset", 32'(irq), 32'h0);
      @(negedge clk);
      check("rvalid_dropped_2", 32'(rsp_s.rvalid), 32'h0);
      rd(32'h00, 32'h0);
      rd(32'h04, 32'h0);
      rd(32'h08, 32'h0);
      rd(32'h0C, 32'h0);
      rd(32'h10, 32'h0);

      // input high across reset release does not set STATUS
      edge_r = 8'hFF;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      wait_cycles(4);
      wr(32'h0C, 32'hFF, 4'hF);
      rd(32'h04, 32'h0);
      rd(32'h08, 32'h0);
      rd(32'h10, 32'hFF);
      check("irq_high_at_release", 32'(irq), 32'h0);

      wait_cycles(3);
      check("queue_drained_end", 32'(exp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
